// File: rtl/frame_rx_pkg.sv
// frame_rx_writer shared types and helpers.
// CRC-8 step used when FRAME_RX_CRC8_EN is defined.
package frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic logic [7:0] crc8_step(
    input logic [7:0] crc,
    input logic [7:0] data
  );
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY)
               : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_rx_check.sv
// Frame check accumulator: modular sum, or CRC-8
// when FRAME_RX_CRC8_EN is defined.
module frame_rx_check
  import frame_rx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_seed,
  input  logic       i_update,
  input  logic [7:0] i_data,
  output logic [7:0] o_result
);

  logic [7:0] acc;
  logic [7:0] base;
  logic [7:0] nxt;

  // Next accumulator value; seed restarts from zero
  always_comb begin
    base = i_seed ? 8'h00 : acc;
`ifdef FRAME_RX_CRC8_EN
    nxt = crc8_step(base, i_data);
`else
    nxt = base + i_data;
`endif
  end

  // Accumulator register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= 8'h00;
    end else if (i_seed || i_update) begin
      acc <= nxt;
    end else if (i_clear) begin
      acc <= 8'h00;
    end
  end

  assign o_result = acc;

endmodule

// File: rtl/frame_rx_writer.sv
// Framed byte stream to circular buffer writer with
// checkpoint rollback. Option: FRAME_RX_CRC8_EN.
module frame_rx_writer
  import frame_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 512,
  parameter int MAX_LEN     = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic                  i_eof,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [15:0]           i_buf_data_size,
  output logic                  o_write_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_push_write_index,
  output logic                  o_pop_write_index,
  output logic                  o_frame_ok,
  output logic                  o_frame_err,
  output logic [15:0]           o_ok_cnt,
  output logic [15:0]           o_chk_err_cnt,
  output logic [15:0]           o_drop_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t state, state_d;
  logic [LEN_W-1:0] len, len_d;

  logic                  we_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  push_d;
  logic                  pop_d;
  logic                  ok_d;
  logic                  err_d;
  logic                  inc_ok;
  logic                  inc_chk;
  logic                  inc_drop;

  logic       chk_clr;
  logic       chk_seed;
  logic       chk_upd;
  logic [7:0] chk_byte;
  logic [7:0] chk_res;

  logic space_ok;
  logic len_lt;
  logic chk_match;

  assign chk_byte  = 8'(i_data);
  assign chk_match = (chk_byte == chk_res);
  assign len_lt    = (len < LEN_W'(MAX_LEN));
  assign space_ok  =
    ({1'b0, i_buf_data_size} + 17'(MAX_LEN))
      <= 17'(BUFFER_SIZE - 1);

  frame_rx_check u_check (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (chk_clr),
    .i_seed   (chk_seed),
    .i_update (chk_upd),
    .i_data   (chk_byte),
    .o_result (chk_res)
  );

  // Next state, length and registered output values
  always_comb begin
    state_d  = state;
    len_d    = len;
    we_d     = 1'b0;
    data_d   = '0;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    inc_ok   = 1'b0;
    inc_chk  = 1'b0;
    inc_drop = 1'b0;
    chk_seed = 1'b0;
    chk_upd  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_valid && i_sof) begin
          unique case (1'b1)
            i_eof: begin
              err_d    = 1'b1;
              inc_drop = 1'b1;
            end
            !i_eof && space_ok: begin
              push_d   = 1'b1;
              we_d     = 1'b1;
              data_d   = i_data;
              chk_seed = 1'b1;
              len_d    = LEN_W'(1);
              state_d  = ST_RECV;
            end
            !i_eof && !space_ok: begin
              err_d    = 1'b1;
              inc_drop = 1'b1;
              state_d  = ST_DROP;
            end
          endcase
        end
      end
      ST_RECV: begin
        if (i_valid) begin
          unique case (1'b1)
            i_sof: begin
              pop_d    = 1'b1;
              err_d    = 1'b1;
              inc_drop = 1'b1;
              state_d  = i_eof ? ST_IDLE
                               : ST_DROP;
            end
            !i_sof && i_eof: begin
              if (chk_match) begin
                ok_d   = 1'b1;
                inc_ok = 1'b1;
              end else begin
                pop_d   = 1'b1;
                err_d   = 1'b1;
                inc_chk = 1'b1;
              end
              state_d = ST_IDLE;
            end
            !i_sof && !i_eof && len_lt: begin
              we_d    = 1'b1;
              data_d  = i_data;
              chk_upd = 1'b1;
              len_d   = len + LEN_W'(1);
            end
            !i_sof && !i_eof && !len_lt: begin
              pop_d    = 1'b1;
              err_d    = 1'b1;
              inc_drop = 1'b1;
              state_d  = ST_DROP;
            end
          endcase
        end
      end
      ST_DROP: begin
        if (i_valid && i_eof) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    chk_clr = (state_d != ST_RECV);
  end

  // State, length, strobes and saturating counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= ST_IDLE;
      len                <= '0;
      o_write_en         <= 1'b0;
      o_data             <= '0;
      o_push_write_index <= 1'b0;
      o_pop_write_index  <= 1'b0;
      o_frame_ok         <= 1'b0;
      o_frame_err        <= 1'b0;
      o_ok_cnt           <= 16'h0;
      o_chk_err_cnt      <= 16'h0;
      o_drop_cnt         <= 16'h0;
    end else begin
      state              <= state_d;
      len                <= len_d;
      o_write_en         <= we_d;
      o_data             <= data_d;
      o_push_write_index <= push_d;
      o_pop_write_index  <= pop_d;
      o_frame_ok         <= ok_d;
      o_frame_err        <= err_d;
      if (inc_ok)
        o_ok_cnt <= sat_inc(o_ok_cnt);
      if (inc_chk)
        o_chk_err_cnt <= sat_inc(o_chk_err_cnt);
      if (inc_drop)
        o_drop_cnt <= sat_inc(o_drop_cnt);
    end
  end

endmodule

// File: tb/tb_frame_rx_writer.sv
// Scoreboard bench for frame_rx_writer.
// Honours FRAME_RX_CRC8_EN for the check byte.
module tb_frame_rx_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        sof = 1'b0;
  logic        eof = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [15:0] bsize = 16'd0;
  logic        o_we;
  logic [7:0]  o_data;
  logic        o_push;
  logic        o_pop;
  logic        o_ok;
  logic        o_err;
  logic [15:0] ok_cnt;
  logic [15:0] chk_cnt;
  logic [15:0] drop_cnt;

  frame_rx_writer dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_valid            (valid),
    .i_sof              (sof),
    .i_eof              (eof),
    .i_data             (data),
    .i_buf_data_size    (bsize),
    .o_write_en         (o_we),
    .o_data             (o_data),
    .o_push_write_index (o_push),
    .o_pop_write_index  (o_pop),
    .o_frame_ok         (o_ok),
    .o_frame_err        (o_err),
    .o_ok_cnt           (ok_cnt),
    .o_chk_err_cnt      (chk_cnt),
    .o_drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       we;
    logic [7:0] d;
    logic       push;
    logic       pop;
    logic       ok;
    logic       err;
  } exp_t;

  exp_t q[$];
  int vecs = 0;
  int errs = 0;
  int e_ok = 0;
  int e_chk = 0;
  int e_drop = 0;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h @cyc %0d",
               name, act, req, cyc);
    end
  endtask

  function automatic exp_t ev(logic we,
                              logic [7:0] d,
                              logic push, logic pop,
                              logic ok, logic err);
    exp_t x;
    x.c = 0; x.we = we; x.d = d;
    x.push = push; x.pop = pop;
    x.ok = ok; x.err = err;
    return x;
  endfunction

  function automatic logic [7:0] ref_chk(
    int n, logic [7:0] b0, logic [7:0] b1);
    logic [7:0] a;
    logic [7:0] b;
    a = 8'h00;
    for (int k = 0; k < n; k++) begin
      b = (k == 0) ? b0 : b1;
`ifdef FRAME_RX_CRC8_EN
      for (int j = 7; j >= 0; j--) begin
        logic fb;
        fb = a[7] ^ b[j];
        a = {a[6:0], 1'b0};
        if (fb) a = a ^ 8'h07;
      end
`else
      a = a + b;
`endif
    end
    return a;
  endfunction

  task automatic put(logic s, logic e,
                     logic [7:0] d,
                     logic has, exp_t x);
    @(negedge clk);
    valid = 1'b1; sof = s; eof = e; data = d;
    if (has) begin
      x.c = cyc + 1;
      q.push_back(x);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0; sof = 1'b0; eof = 1'b0;
    end
  endtask

  task automatic frame(int n, logic [7:0] b0,
                       logic [7:0] b1,
                       logic [7:0] ck);
    exp_t none;
    none = ev(0, 0, 0, 0, 0, 0);
    put(1, 0, b0, 1, ev(1, b0, 1, 0, 0, 0));
    if (n > 1) put(0, 0, b1, 1, ev(1, b1, 0, 0, 0, 0));
    if (ck == ref_chk(n, b0, b1)) begin
      put(0, 1, ck, 1, ev(0, 0, 0, 0, 1, 0));
      e_ok++;
    end else begin
      put(0, 1, ck, 1, ev(0, 0, 0, 1, 0, 1));
      e_chk++;
    end
  endtask

  task automatic cnts(string tag);
    idle(1);
    chk({tag, "_ok_cnt"}, ok_cnt, e_ok);
    chk({tag, "_chk_cnt"}, chk_cnt, e_chk);
    chk({tag, "_drop_cnt"}, drop_cnt, e_drop);
  endtask

  // Monitor: per-cycle exclusivity and scoreboard
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      chk("push_pop_excl", o_push & o_pop, 0);
      chk("write_pop_excl", o_we & o_pop, 0);
      while (q.size() > 0 && q[0].c < cyc) begin
        x = q.pop_front();
        vecs++; errs++;
        $display("FAIL missed_event: got none want cyc %0d",
                 x.c);
      end
      if (o_we | o_push | o_pop | o_ok | o_err) begin
        if (q.size() > 0 && q[0].c == cyc) begin
          x = q.pop_front();
          chk("ev_we", o_we, x.we);
          if (x.we) chk("ev_data", o_data, x.d);
          chk("ev_push", o_push, x.push);
          chk("ev_pop", o_pop, x.pop);
          chk("ev_ok", o_ok, x.ok);
          chk("ev_err", o_err, x.err);
        end else begin
          vecs++; errs++;
          $display("FAIL unexpected_event: got %b%b%b%b%b want none @cyc %0d",
                   o_we, o_push, o_pop, o_ok, o_err, cyc);
        end
      end
    end
  end

  initial begin
    exp_t none;
    logic [7:0] ck;
    none = ev(0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_we", o_we, 0);
    chk("rst_push", o_push, 0);
    chk("rst_pop", o_pop, 0);
    chk("rst_ok", o_ok, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ok_cnt", ok_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // basic frame, sum check 0x30
`ifdef FRAME_RX_CRC8_EN
    frame(2, 8'h10, 8'h20, ref_chk(2, 8'h10, 8'h20));
`else
    frame(2, 8'h10, 8'h20, 8'h30);
`endif
    cnts("basic");

    // single byte good, then bad check 0x08
`ifdef FRAME_RX_CRC8_EN
    ck = 8'h07;
`else
    ck = 8'h01;
`endif
    frame(1, 8'h01, 8'h00, ck);
    frame(1, 8'h01, 8'h00, 8'h08);
    cnts("check");

    // MAX_LEN + 1 payload bytes
    for (int i = 0; i < 65; i++) begin
      if (i < 64)
        put(i == 0, 0, 8'(i + 1), 1,
            ev(1, 8'(i + 1), i == 0, 0, 0, 0));
      else
        put(0, 0, 8'h99, 1, ev(0, 0, 0, 1, 0, 1));
    end
    e_drop++;
    put(0, 0, 8'hAA, 0, none);
    put(0, 1, 8'hBB, 0, none);
    cnts("long");

    // space check boundary
    bsize = 16'd448;
    put(1, 0, 8'h05, 1, ev(0, 0, 0, 0, 0, 1));
    e_drop++;
    put(0, 0, 8'h06, 0, none);
    put(0, 1, 8'h0B, 0, none);
    idle(1);
    bsize = 16'd447;
    frame(2, 8'h05, 8'h06, ref_chk(2, 8'h05, 8'h06));
    bsize = 16'd0;
    cnts("space");

    // abort by SOF, then runt
    put(1, 0, 8'hAA, 1, ev(1, 8'hAA, 1, 0, 0, 0));
    put(0, 0, 8'hBB, 1, ev(1, 8'hBB, 0, 0, 0, 0));
    put(1, 0, 8'hCC, 1, ev(0, 0, 0, 1, 0, 1));
    e_drop++;
    put(0, 0, 8'hDD, 0, none);
    put(0, 1, 8'hEE, 0, none);
    put(1, 1, 8'h55, 1, ev(0, 0, 0, 0, 0, 1));
    e_drop++;
    cnts("abort");

    // back-to-back: bad, good, good
    frame(1, 8'h11, 8'h00, 8'h22);
    frame(2, 8'h40, 8'h02, ref_chk(2, 8'h40, 8'h02));
    frame(1, 8'h03, 8'h00, ref_chk(1, 8'h03, 8'h00));
    cnts("b2b");

    // reset while a payload write is on the outputs
    put(1, 0, 8'h61, 1, ev(1, 8'h61, 1, 0, 0, 0));
    put(0, 0, 8'h62, 0, none);
    @(posedge clk);
    #1;
    chk("pre_rst_we", o_we, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", o_we, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_ok_cnt", ok_cnt, 0);
    chk("mid_rst_chk_cnt", chk_cnt, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    e_ok = 0; e_chk = 0; e_drop = 0;
    @(negedge clk);
    valid = 1'b0; sof = 1'b0; eof = 1'b0;
    rst_n = 1'b1;
    idle(1);
    frame(2, 8'h10, 8'h20, ref_chk(2, 8'h10, 8'h20));
    cnts("post_rst");

    idle(3);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
